serial_addsub: RTL and testbench

Bit-serial N-bit adder/subtractor built around one fas full adder/subtractor cell and a carry flip-flop.
It feeds the fas cell one operand bit pair per clock, LSB first, and collects the sum bits into a result register.
A start/done handshake connects it to a controller or testbench.
Result, carry-out and signed overflow are presented after N cycles.

---
 rtl/serial_addsub_pkg.sv | 15 +
 rtl/fas.sv | 25 ++
 rtl/serial_addsub.sv | 118 +++++++++++
 tb/tb_serial_addsub.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_addsub_pkg;

  // Controller states: waiting, shifting bits through the cell, result valid.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sas_state_t;

  // Encoding of the a_ns operation-select input.
  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

endpackage : serial_addsub_pkg

// File: rtl/fas.sv
// One-bit full adder/subtractor cell.
//   a_ns = 1 : {cout, s} = a + b  + cin
//   a_ns = 0 : {cout, s} = a + ~b + cin
// Subtraction works as two's complement when the caller seeds cin with 1.
module fas
  import serial_addsub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic a_ns,
  output logic s,
  output logic cout
);

  logic b_eff;

  // Invert B for subtraction, then form a plain full-adder sum and majority carry.
  always_comb begin
    b_eff = (a_ns == OP_ADD) ? b : ~b;
    s     = a ^ b_eff ^ cin;
    cout  = (a & b_eff) | (a & cin) | (b_eff & cin);
  end

endmodule : fas

// File: rtl/serial_addsub.sv
// Bit-serial N-bit adder/subtractor.
// Operands are latched on an accepted start, then one bit pair per clock is
// pushed LSB-first through a single fas cell. The sum bits enter the result
// register at the MSB and shift right, so after N edges the result is in
// place. cout and signed overflow are captured on the MSB edge, and done
// pulses for one cycle in the DONE state.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         a_ns,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         cout,
  output logic         ovf
);

  localparam int              CW       = $clog2(N);
  localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);

  sas_state_t    state;
  sas_state_t    state_nxt;
  logic [CW-1:0] cnt;
  logic          carry_q;
  logic          op_q;
  logic [N-1:0]  a_sr;
  logic [N-1:0]  b_sr;
  logic          fas_s;
  logic          fas_cout;
  logic          accept;
  logic          last_bit;

  // A start is taken in IDLE or DONE; while RUN it is ignored so the
  // latched operands cannot be disturbed mid-operation.
  assign accept   = start && (state != RUN);
  assign last_bit = (state == RUN) && (cnt == CNT_LAST);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // The single arithmetic cell, fed from the shift-register LSBs.
  fas u_fas (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry_q),
    .a_ns (op_q),
    .s    (fas_s),
    .cout (fas_cout)
  );

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; DONE accepts a new start for back-to-back operation.
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, bit-serial shift, carry chain and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      carry_q <= 1'b0;
      op_q    <= 1'b0;
      a_sr    <= '0;
      b_sr    <= '0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      a_sr    <= a;
      b_sr    <= b;
      op_q    <= a_ns;
      // Subtract seeds the carry with 1 to complete the two's complement of B.
      carry_q <= ~a_ns;
      cnt     <= '0;
      result  <= '0;
    end else if (state == RUN) begin
      result  <= {fas_s, result[N-1:1]};
      carry_q <= fas_cout;
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      if (last_bit) begin
        // Clear explicitly so non-power-of-two N also restarts at zero.
        cnt  <= '0;
        cout <= fas_cout;
        // Signed overflow: carry into the MSB differs from carry out of it.
        ovf  <= carry_q ^ fas_cout;
      end else begin
        cnt  <= cnt + CW'(1);
      end
    end
  end

endmodule : serial_addsub

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (N=8): a table of directed vectors
// plus hand-written sequences for ignored start, back-to-back start and
// mid-operation reset.
module tb_serial_addsub;

  localparam int N        = 8;
  localparam int LATENCY  = N;   // negedges from first RUN cycle to done
  localparam int WAIT_MAX = 40;

  logic         clk;
  logic         rst;
  logic         start;
  logic         a_ns;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        name;
    logic         op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] exp_res;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[8];

  serial_addsub #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_ns   (a_ns),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present an operation for one posedge; returns at the first RUN negedge.
  task automatic start_op(input logic op, input logic [N-1:0] va, input logic [N-1:0] vb);
    @(negedge clk);
    start = 1'b1;
    a_ns  = op;
    a     = va;
    b     = vb;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sample on negedges until done, counting cycles and busy cycles.
  task automatic wait_done(output int edges, output int busy_cycles);
    edges       = 0;
    busy_cycles = 0;
    while (!done && edges < WAIT_MAX) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int edges;
    int busy_cycles;
    start_op(v.op, v.a, v.b);
    wait_done(edges, busy_cycles);
    check({v.name, " latency"}, edges, LATENCY);
    check({v.name, " busy_cycles"}, busy_cycles, N);
    check({v.name, " result"}, result, v.exp_res);
    check({v.name, " cout"}, cout, v.exp_cout);
    check({v.name, " ovf"}, ovf, v.exp_ovf);
    @(negedge clk);
    check({v.name, " done_one_cycle"}, done, 1'b0);
    check({v.name, " result_held"}, result, v.exp_res);
  endtask

  initial begin
    int edges;
    int busy_cycles;
    int seen_done;

    vecs[0] = '{"add_01_01", 1'b1, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{"add_ff_01", 1'b1, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{"add_7f_01", 1'b1, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{"sub_05_03", 1'b0, 8'h05, 8'h03, 8'h02, 1'b1, 1'b0};
    vecs[4] = '{"sub_03_05", 1'b0, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0};
    vecs[5] = '{"sub_80_01", 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    vecs[6] = '{"sub_00_00", 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{"add_80_80", 1'b1, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};

    rst   = 1'b1;
    start = 1'b0;
    a_ns  = 1'b1;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset result", result, 8'h00);
    check("reset cout", cout, 1'b0);
    check("reset ovf", ovf, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Start pulsed during RUN must be ignored.
    start_op(1'b1, 8'h10, 8'h20);
    repeat (2) @(negedge clk);
    start = 1'b1;
    a_ns  = 1'b0;
    a     = 8'hFF;
    b     = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    wait_done(edges, busy_cycles);
    check("ignored_start latency", edges, LATENCY - 3);
    check("ignored_start result", result, 8'h30);
    check("ignored_start cout", cout, 1'b0);
    check("ignored_start ovf", ovf, 1'b0);

    // Back-to-back: start accepted in the DONE cycle.
    start = 1'b1;
    a_ns  = 1'b0;
    a     = 8'h0A;
    b     = 8'h01;
    @(negedge clk);
    start = 1'b0;
    check("b2b busy", busy, 1'b1);
    check("b2b done_low", done, 1'b0);
    wait_done(edges, busy_cycles);
    check("b2b latency", edges, LATENCY);
    check("b2b result", result, 8'h09);
    check("b2b cout", cout, 1'b1);
    check("b2b ovf", ovf, 1'b0);
    @(negedge clk);
    check("b2b done_one_cycle", done, 1'b0);

    // Reset in the middle of an operation aborts it without a done pulse.
    start_op(1'b1, 8'h55, 8'h55);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort result", result, 8'h00);
    check("abort cout", cout, 1'b0);
    check("abort ovf", ovf, 1'b0);
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) seen_done = 1;
      @(negedge clk);
    end
    check("abort no_activity", seen_done, 0);
    run_vec('{"add_55_55", 1'b1, 8'h55, 8'h55, 8'hAA, 1'b0, 1'b1});

    // Reset and start in the same cycle: reset wins.
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    a_ns  = 1'b1;
    a     = 8'h01;
    b     = 8'h01;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("rst_start busy", busy, 1'b0);
    check("rst_start result", result, 8'h00);
    repeat (3) @(negedge clk);
    check("rst_start still_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_addsub
